// File: rtl/gpib_cic_sequencer.sv
// GPIB controller-in-charge sequencer: IFC pulse, UNL/MLA/MTA command phase under ATN,
// then a talker data phase with EOI on the final byte, all with the source handshake.
module gpib_cic_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned IFC_CYCLES = 100,
  parameter int unsigned HS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_ifc,
  input  logic                  xfer_valid,
  output logic                  xfer_ready,
  input  logic [ADDR_WIDTH-1:0] xfer_talk_addr,
  input  logic [ADDR_WIDTH-1:0] xfer_listen_addr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  input  logic                  tx_last,
  output logic                  tx_ready,
  input  logic                  nrfd_in,
  input  logic                  ndac_in,
  output logic [DATA_WIDTH-1:0] dio_out,
  output logic                  dio_oe,
  output logic                  atn_out,
  output logic                  ifc_out,
  output logic                  eoi_out,
  output logic                  dav_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  addr_err
);

  localparam int unsigned CntMax = (IFC_CYCLES > HS_TIMEOUT) ? IFC_CYCLES : HS_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [ADDR_WIDTH-1:0] AddrRsvd = '1;

  typedef enum logic [2:0] {StIdle, StIfc, StCmd, StAtnRel, StData} state_e;
  typedef enum logic [1:0] {HsWaitRfd, HsDavOn, HsWaitDac} hs_e;

  state_e                state_q, state_d;
  hs_e                   hs_q, hs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic                  loaded_q, loaded_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] talk_q, talk_d, listen_q, listen_d;
  logic [DATA_WIDTH-1:0] dio_q, dio_d;
  logic                  oe_q, oe_d, atn_q, atn_d, ifc_q, ifc_d, eoi_q, eoi_d, dav_q, dav_d;
  logic                  done_q, done_d, tmo_q, tmo_d, aerr_q, aerr_d;
  logic                  take_tx, counting, tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      hs_q     <= HsWaitRfd;
      cnt_q    <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      last_q   <= 1'b0;
      talk_q   <= '0;
      listen_q <= '0;
      dio_q    <= '0;
      oe_q     <= 1'b0;
      atn_q    <= 1'b0;
      ifc_q    <= 1'b0;
      eoi_q    <= 1'b0;
      dav_q    <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      last_q   <= last_d;
      talk_q   <= talk_d;
      listen_q <= listen_d;
      dio_q    <= dio_d;
      oe_q     <= oe_d;
      atn_q    <= atn_d;
      ifc_q    <= ifc_d;
      eoi_q    <= eoi_d;
      dav_q    <= dav_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      aerr_q   <= aerr_d;
    end
  end

  // Waiting for tx_valid (DATA with no byte loaded) is exempt from the handshake timeout.
  assign counting = ((state_q == StCmd) || ((state_q == StData) && loaded_q)) &&
                    ((hs_q == HsWaitRfd) || (hs_q == HsWaitDac));
  assign tmo_hit  = counting && (cnt_q == CntW'(HS_TIMEOUT - 1));
  assign take_tx  = (state_q == StData) && (hs_q == HsWaitRfd) && !loaded_q && tx_valid;

  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    last_d   = last_q;
    talk_d   = talk_q;
    listen_d = listen_q;
    dio_d    = dio_q;
    oe_d     = oe_q;
    atn_d    = atn_q;
    ifc_d    = ifc_q;
    eoi_d    = eoi_q;
    dav_d    = dav_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    aerr_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_ifc) begin
          state_d = StIfc;
          ifc_d   = 1'b1;
          atn_d   = 1'b0;
        end else if (xfer_valid) begin
          if ((xfer_talk_addr == AddrRsvd) || (xfer_listen_addr == AddrRsvd)) begin
            aerr_d = 1'b1;
          end else begin
            state_d  = StCmd;
            hs_d     = HsWaitRfd;
            idx_d    = 2'd0;
            talk_d   = xfer_talk_addr;
            listen_d = xfer_listen_addr;
            atn_d    = 1'b1;
            oe_d     = 1'b1;
            dio_d    = DATA_WIDTH'(8'h3F);
          end
        end
      end

      StIfc: begin
        if (cnt_q == CntW'(IFC_CYCLES - 1)) begin
          state_d = StIdle;
          ifc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StCmd, StData: begin
        case (hs_q)
          HsWaitRfd: begin
            if ((state_q == StData) && !loaded_q) begin
              if (tx_valid) begin
                loaded_d = 1'b1;
                dio_d    = tx_data;
                oe_d     = 1'b1;
                eoi_d    = tx_last;
                last_d   = tx_last;
              end
            end else if (!nrfd_in) begin
              hs_d  = HsDavOn;
              dav_d = 1'b1;
            end else if (tmo_hit) begin
              state_d = StIdle;
              tmo_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end

          // Settling cycle with DAV asserted; NDAC is only looked at from the next cycle.
          HsDavOn: hs_d = HsWaitDac;

          HsWaitDac: begin
            if (!ndac_in) begin
              dav_d = 1'b0;
              hs_d  = HsWaitRfd;
              if (state_q == StCmd) begin
                if (idx_q == 2'd2) begin
                  state_d = StAtnRel;
                  atn_d   = 1'b0;
                  oe_d    = 1'b0;
                end else begin
                  idx_d = idx_q + 2'd1;
                  dio_d = (idx_q == 2'd0) ? (DATA_WIDTH'(8'h20) | DATA_WIDTH'(listen_q))
                                          : (DATA_WIDTH'(8'h40) | DATA_WIDTH'(talk_q));
                end
              end else begin
                loaded_d = 1'b0;
                oe_d     = 1'b0;
                eoi_d    = 1'b0;
                if (last_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                end
              end
            end else if (tmo_hit) begin
              state_d = StIdle;
              tmo_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end

          default: hs_d = HsWaitRfd;
        endcase
      end

      StAtnRel: begin
        state_d  = StData;
        hs_d     = HsWaitRfd;
        loaded_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase

    // Abort drops every bus line in the same cycle the error pulse is raised.
    if (tmo_d) begin
      hs_d     = HsWaitRfd;
      loaded_d = 1'b0;
      dav_d    = 1'b0;
      atn_d    = 1'b0;
      eoi_d    = 1'b0;
      oe_d     = 1'b0;
    end
  end

  assign xfer_ready  = (state_q == StIdle) && !start_ifc && !rst;
  assign tx_ready    = take_tx && !rst;
  assign busy        = (state_q != StIdle);
  assign dio_out     = dio_q;
  assign dio_oe      = oe_q;
  assign atn_out     = atn_q;
  assign ifc_out     = ifc_q;
  assign eoi_out     = eoi_q;
  assign dav_out     = dav_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign addr_err    = aerr_q;

endmodule
